ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_sram_ctrl : zero-wait-state AHB-Lite to synchronous SRAM bridge with  |
// |                 a one-entry write buffer and read-data byte merging.      |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module ahb_sram_ctrl #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  logic          w_valid;
  logic          w_rd_ap;
  logic          w_wr_ap;
  logic [AW-1:0] w_ap_addr;
  logic [3:0]    w_ap_be;
  logic          w_direct_wr;
  logic          w_buf_load;
  logic          w_buf_commit;
  logic          w_buf_hit;
  logic          w_unused;

  logic          r_rd_dp;
  logic          r_wr_dp;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_wr_addr;
  logic [3:0]    r_wr_be;
  logic          r_buf_valid;
  logic [AW-1:0] r_buf_addr;
  logic [3:0]    r_buf_be;
  logic [31:0]   r_buf_data;

  // Gating with HRESETn keeps the SRAM idle while reset is held.
  assign w_valid   = HRESETn & HSEL & HREADY & HTRANS[1];
  assign w_rd_ap   = w_valid & ~HWRITE;
  assign w_wr_ap   = w_valid & HWRITE;
  assign w_ap_addr = HADDR[AW+1:2];
  assign w_unused  = &{1'b0, HADDR[31:AW+2], HTRANS[0]};

  always_comb begin
    case (HSIZE)
      3'd0:    w_ap_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_ap_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_ap_be = 4'b1111;
    endcase
  end

  // A read address phase owns the SRAM port, so a colliding write is parked.
  assign w_direct_wr  = r_wr_dp & ~w_rd_ap;
  assign w_buf_load   = r_wr_dp & w_rd_ap;
  assign w_buf_commit = r_buf_valid & ~w_rd_ap & ~r_wr_dp;
  assign w_buf_hit    = r_buf_valid & (r_buf_addr == r_rd_addr);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_dp     <= 1'b0;
      r_wr_dp     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_be     <= 4'b0000;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_be    <= 4'b0000;
      r_buf_data  <= 32'h0;
    end else begin
      if (HREADY) begin
        r_rd_dp   <= w_rd_ap;
        r_wr_dp   <= w_wr_ap;
        r_wr_addr <= w_ap_addr;
        r_wr_be   <= w_ap_be;
        if (w_rd_ap) begin
          r_rd_addr <= w_ap_addr;
        end
      end
      if (w_buf_load) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= r_wr_addr;
        r_buf_be    <= r_wr_be;
        r_buf_data  <= HWDATA;
      end else if (w_buf_commit) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = w_ap_addr;
    SRAMWDATA = HWDATA;
    if (w_rd_ap) begin
      SRAMCS0  = 1'b1;
      SRAMADDR = w_ap_addr;
    end else if (w_direct_wr) begin
      SRAMCS0   = 1'b1;
      SRAMADDR  = r_wr_addr;
      SRAMWEN   = r_wr_be;
      SRAMWDATA = HWDATA;
    end else if (w_buf_commit) begin
      SRAMCS0   = 1'b1;
      SRAMADDR  = r_buf_addr;
      SRAMWEN   = r_buf_be;
      SRAMWDATA = r_buf_data;
    end
  end

  // Bytes still parked in the buffer are newer than the SRAM copy.
  always_comb begin
    HRDATA = 32'h0;
    if (r_rd_dp) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (w_buf_hit && r_buf_be[i]) ? r_buf_data[8*i +: 8]
                                                       : SRAMRDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  a_no_wr_with_buf : assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(r_wr_dp && r_buf_valid));

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ahb_sram_ctrl : directed scoreboard bench for ahb_sram_ctrl.           |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_ahb_sram_ctrl;
  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS0;
  logic [AW-1:0] SRAMADDR;

  ahb_sram_ctrl #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS0(SRAMCS0), .SRAMADDR(SRAMADDR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0]    wen;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } sram_exp_t;

  sram_exp_t   sram_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  logic        tb_rd_dp;

  // Behavioural synchronous SRAM: read data appears the cycle after the read.
  always @(posedge HCLK) begin
    if (SRAMCS0 === 1'b1) begin
      if (SRAMWEN == 4'b0000) begin
        SRAMRDATA <= mem[SRAMADDR];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
        end
      end
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tb_rd_dp <= 1'b0;
    else if (HREADY) tb_rd_dp <= HSEL & HTRANS[1] & ~HWRITE;
  end

  always @(negedge HCLK) begin
    sram_exp_t e;
    logic [31:0] r;
    n_checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      n_errors++;
      $display("FAIL hready_resp: got HREADYOUT=%b HRESP=%b, want 1/0", HREADYOUT, HRESP);
    end
    n_checks++;
    if (SRAMCS0 === 1'b1) begin
      if (sram_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_sram @%0t: got wen=%b addr=%0d data=%h, want no access",
                 $time, SRAMWEN, SRAMADDR, SRAMWDATA);
      end else begin
        e = sram_q.pop_front();
        if (SRAMWEN !== e.wen || SRAMADDR !== e.addr ||
            (e.wen != 4'b0000 && SRAMWDATA !== e.wdata)) begin
          n_errors++;
          $display("FAIL sram_access @%0t: got wen=%b addr=%0d data=%h, want wen=%b addr=%0d data=%h",
                   $time, SRAMWEN, SRAMADDR, SRAMWDATA, e.wen, e.addr, e.wdata);
        end
      end
    end else if (SRAMCS0 !== 1'b0 || SRAMWEN !== 4'b0000) begin
      n_errors++;
      $display("FAIL sram_idle @%0t: got cs=%b wen=%b, want 0/0000", $time, SRAMCS0, SRAMWEN);
    end
    n_checks++;
    if (tb_rd_dp) begin
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected @%0t: got HRDATA=%h, want no read expected", $time, HRDATA);
      end else begin
        r = rd_q.pop_front();
        if (HRDATA !== r) begin
          n_errors++;
          $display("FAIL rd_data @%0t: got HRDATA=%h, want %h", $time, HRDATA, r);
        end
      end
    end else if (HRDATA !== 32'h0) begin
      n_errors++;
      $display("FAIL rd_idle @%0t: got HRDATA=%h, want 00000000", $time, HRDATA);
    end
  end

  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] sz, input logic [31:0] addr,
                      input logic rdy, input logic [31:0] wd);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = sz;
    HADDR = addr; HREADY = rdy; HWDATA = wd;
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    beat(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 1'b1, wd);
  endtask

  task automatic exp_sram(input logic [3:0] wen, input logic [AW-1:0] a, input logic [31:0] d);
    sram_exp_t e;
    e.wen = wen; e.addr = a; e.wdata = d;
    sram_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sram_q.size() != 0 || rd_q.size() != 0) begin
      n_errors++;
      $display("FAIL drained_%s: got pending sram=%0d rd=%0d, want 0/0", name, sram_q.size(), rd_q.size());
      sram_q.delete();
      rd_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (SRAMCS0 !== 1'b0 || SRAMWEN !== 4'b0000 || HRDATA !== 32'h0 ||
        HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_%s: got cs=%b wen=%b hrdata=%h hready=%b hresp=%b, want 0/0000/0/1/0",
               name, SRAMCS0, SRAMWEN, HRDATA, HREADYOUT, HRESP);
    end
  endtask

  localparam logic [1:0] NS = 2'b10;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[4]  = 32'h1122_3344;
    mem[8]  = 32'h5566_7788;
    mem[9]  = 32'h99AA_BBCC;
    mem[16] = 32'hCAFE_F00D;
    SRAMRDATA = 32'h0;
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'h0; HREADY = 1'b1;
    #2;
    check_reset_outputs("initial");
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle(32'h0);
    check_reset_outputs("post_release");

    // Byte write 0xAA @0x13 then read @0x10: merged read, commit on idle.
    exp_sram(4'b0000, 12'd4, 32'h0);
    exp_sram(4'b1000, 12'd4, 32'hAA00_0000);
    rd_q.push_back(32'hAA22_3344);
    beat(1'b1, NS, 1'b1, 3'd0, 32'h13, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h10, 1'b1, 32'hAA00_0000);
    idle(32'h0);
    idle(32'h0);
    check_drained("byte_wr_rd");

    // Word write directly in data phase.
    exp_sram(4'b1111, 12'd4, 32'hDEAD_BEEF);
    beat(1'b1, NS, 1'b1, 3'd2, 32'h10, 1'b1, 32'h0);
    idle(32'hDEAD_BEEF);
    idle(32'h0);
    check_drained("word_wr");

    // Upper address bits wrap onto word 4.
    exp_sram(4'b0000, 12'd4, 32'h0);
    rd_q.push_back(32'hDEAD_BEEF);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h0000_4010, 1'b1, 32'h0);
    idle(32'h0);
    idle(32'h0);
    check_drained("wrap");

    // Halfword write held in buffer through three reads.
    exp_sram(4'b0000, 12'd8, 32'h0);
    exp_sram(4'b0000, 12'd9, 32'h0);
    exp_sram(4'b0000, 12'd8, 32'h0);
    exp_sram(4'b1100, 12'd8, 32'hBEEF_0000);
    rd_q.push_back(32'hBEEF_7788);
    rd_q.push_back(32'h99AA_BBCC);
    rd_q.push_back(32'hBEEF_7788);
    beat(1'b1, NS, 1'b1, 3'd1, 32'h22, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h20, 1'b1, 32'hBEEF_0000);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h24, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h20, 1'b1, 32'h0);
    idle(32'h0);
    idle(32'h0);
    check_drained("hw_buffer");

    // Back-to-back writes all go direct.
    exp_sram(4'b1111, 12'd0, 32'h1020_3040);
    exp_sram(4'b1111, 12'd1, 32'h5060_7080);
    exp_sram(4'b1111, 12'd2, 32'h90A0_B0C0);
    beat(1'b1, NS, 1'b1, 3'd2, 32'h0, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b1, 3'd2, 32'h4, 1'b1, 32'h1020_3040);
    beat(1'b1, NS, 1'b1, 3'd2, 32'h8, 1'b1, 32'h5060_7080);
    idle(32'h90A0_B0C0);
    idle(32'h0);
    check_drained("wr_burst");

    // HREADY low: read data phase extends, stalled write address ignored.
    exp_sram(4'b0000, 12'd9, 32'h0);
    rd_q.push_back(32'h99AA_BBCC);
    rd_q.push_back(32'h99AA_BBCC);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h24, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b1, 3'd2, 32'h30, 1'b0, 32'h0);
    idle(32'h1234_5678);
    idle(32'h0);
    check_drained("hready_low");

    // Reset while a write sits in the buffer.
    exp_sram(4'b0000, 12'd17, 32'h0);
    beat(1'b1, NS, 1'b1, 3'd0, 32'h40, 1'b1, 32'h0);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h44, 1'b1, 32'h0000_0077);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
    HRESETn = 1'b0;
    #2;
    check_reset_outputs("mid_buffer");
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle(32'h0);
    idle(32'h0);
    check_drained("reset_discard");
    n_checks++;
    if (mem[16] !== 32'hCAFE_F00D) begin
      n_errors++;
      $display("FAIL reset_no_commit: got mem[16]=%h, want cafef00d", mem[16]);
    end
    exp_sram(4'b0000, 12'd16, 32'h0);
    rd_q.push_back(32'hCAFE_F00D);
    beat(1'b1, NS, 1'b0, 3'd2, 32'h40, 1'b1, 32'h0);
    idle(32'h0);
    idle(32'h0);
    check_drained("read_after_reset");

    repeat (2) @(posedge HCLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
